// File: rtl/counter_seq_pkg.sv
// Shared state encoding and direction constants for the counter sequencer.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a step-enable tick once every 2**PRESCALE_BITS enabled cycles.
// The counter freezes when en is low; sclr has priority over en.
module tick_gen #(
    parameter int PRESCALE_BITS = 22
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sclr,
    output logic tick
);

    localparam logic [PRESCALE_BITS-1:0] PRE_ONE = {{(PRESCALE_BITS-1){1'b0}}, 1'b1};
    localparam logic [PRESCALE_BITS-1:0] PRE_MAX = {PRESCALE_BITS{1'b1}};

    logic [PRESCALE_BITS-1:0] prescaler;

    // Prescaler register; the all-ones value wraps to zero by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= {PRESCALE_BITS{1'b0}};
        end else if (sclr) begin
            prescaler <= {PRESCALE_BITS{1'b0}};
        end else if (en) begin
            prescaler <= prescaler + PRE_ONE;
        end else begin
            prescaler <= prescaler;
        end
    end

    assign tick = (prescaler == PRE_MAX);

endmodule

// File: rtl/counter_sequencer.sv
// Sequencer for a count datapath: start/pause/resume/clear, direction and terminal value.
// Optional AUTO_RELOAD_EN: terminal tick reloads the launch value and stays in RUN.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int PRESCALE_BITS = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    seq_state_t       state, state_next;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] limit_lat, limit_next;
    logic             dir_lat, dir_next;
    logic             done_next;
    logic             launch, pause_cmd, pre_en, pre_tick;
    logic [WIDTH-1:0] terminal, reload_val;

    // start outranks stop, so stop only counts as a command when start is low
    assign launch    = !clear && start && ((state == IDLE) || (state == DONE));
    assign pause_cmd = stop && !start;
    assign pre_en    = (state == RUN) && !clear && !pause_cmd;
    assign tick      = pre_en && pre_tick;
    assign busy      = (state == RUN) || (state == PAUSE);
    assign terminal   = (dir_lat == DIR_DOWN) ? CNT_ZERO : limit_lat;
    assign reload_val = (dir_lat == DIR_DOWN) ? limit_lat : CNT_ZERO;

    tick_gen #(
        .PRESCALE_BITS(PRESCALE_BITS)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (pre_en),
        .sclr (clear || launch),
        .tick (pre_tick)
    );

    // Next-state, next-count and done-pulse decode.
    always_comb begin
        state_next = state;
        count_next = count;
        dir_next   = dir_lat;
        limit_next = limit_lat;
        done_next  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (clear) begin
                    state_next = IDLE;
                    count_next = CNT_ZERO;
                end else if (start) begin
                    state_next = RUN;
                    dir_next   = dir;
                    limit_next = limit;
                    count_next = (dir == DIR_DOWN) ? limit : CNT_ZERO;
                end else begin
                    state_next = state;
                end
            end
            RUN: begin
                if (clear) begin
                    state_next = IDLE;
                    count_next = CNT_ZERO;
                end else if (pause_cmd) begin
                    state_next = PAUSE;
                end else if (pre_tick) begin
                    if (count == terminal) begin
                        done_next = 1'b1;
`ifdef AUTO_RELOAD_EN
                        count_next = reload_val;
`else
                        state_next = DONE;
`endif
                    end else if (dir_lat == DIR_DOWN) begin
                        count_next = count - CNT_ONE;
                    end else begin
                        count_next = count + CNT_ONE;
                    end
                end else begin
                    state_next = RUN;
                end
            end
            PAUSE: begin
                if (clear) begin
                    state_next = IDLE;
                    count_next = CNT_ZERO;
                end else if (start) begin
                    state_next = RUN;
                end else begin
                    state_next = PAUSE;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = CNT_ZERO;
            end
        endcase
    end

    // State, count, launch latches and done pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= CNT_ZERO;
            dir_lat   <= 1'b0;
            limit_lat <= CNT_ZERO;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            dir_lat   <= dir_next;
            limit_lat <= limit_next;
            done      <= done_next;
        end
    end

endmodule
